// File: rtl/multi_cycle_rv_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/WB FSM with a req/ack fetch port and one instruction in flight.
// Build option: define CORE_BRANCH_EN to add conditional branches; otherwise op 1100011 halts as illegal.
module multi_cycle_rv_core #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            retire_o,
  output logic [XLEN-1:0] retire_pc_o,
  output logic            halt_o,
  input  logic [4:0]      dbg_raddr_i,
  output logic [XLEN-1:0] dbg_rdata_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int RAW = $clog2(NREG);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_regs [NREG];
`ifdef CORE_BRANCH_EN
  logic            r_take;
  logic [XLEN-1:0] r_target;
`endif

  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_is_r;
  logic            w_is_i;
  logic            w_is_b;
  logic            w_legal;
  logic            w_idx_ok;
  logic            w_alt;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_next_pc;

  function automatic logic reg_ok(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SHW-1:0]         sh;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sra_res;
    logic [XLEN-1:0]        res;
    sh      = b[SHW-1:0];
    sa      = a;
    sra_res = sa >>> sh;
    case (f3)
      3'b000:  res = alt ? a - b : a + b;
      3'b001:  res = a << sh;
      3'b010:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  res = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  res = a ^ b;
      3'b101:  res = alt ? sra_res : a >> sh;
      3'b110:  res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

`ifdef CORE_BRANCH_EN
  function automatic logic br_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic c;
    case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = ($signed(a) < $signed(b));
      3'b101:  c = ($signed(a) >= $signed(b));
      3'b110:  c = (a < b);
      3'b111:  c = (a >= b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic            w_take;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_imm_b;
  assign w_imm_b  = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_take   = w_is_b && br_cond(w_f3, r_a, r_b);
  assign w_target = r_pc + r_imm;
  assign w_is_b   = (w_op == OP_B);
  assign w_next_pc = r_take ? r_target : r_pc + XLEN'(4);
`else
  assign w_is_b    = 1'b0;
  assign w_next_pc = r_pc + XLEN'(4);
`endif

  assign w_op    = r_ir[6:0];
  assign w_rd    = r_ir[11:7];
  assign w_f3    = r_ir[14:12];
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_f7    = r_ir[31:25];
  assign w_is_r  = (w_op == OP_R);
  assign w_is_i  = (w_op == OP_I);
  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_opb   = w_is_i ? r_imm : r_b;
  // Only shifts carry a funct7 in I-type; addi with imm bit 10 set must not subtract.
  assign w_alt   = w_is_r ? w_f7[5] : (w_f3 == 3'b101) && w_f7[5];

  always_comb begin
    w_legal = 1'b0;
    if (w_is_r) begin
      w_legal = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    end else if (w_is_i) begin
      case (w_f3)
        3'b001:  w_legal = (w_f7 == 7'h00);
        3'b101:  w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        default: w_legal = 1'b1;
      endcase
    end else if (w_is_b) begin
      w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
    end
  end

  // Only fields that name registers for this format are range-checked.
  assign w_idx_ok = reg_ok(w_rs1) && (!(w_is_r || w_is_b) || reg_ok(w_rs2)) &&
                    (w_is_b || reg_ok(w_rd));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
`ifdef CORE_BRANCH_EN
      r_take  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack_i) begin
            r_ir    <= imem_rdata_i;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs1[RAW-1:0]];
          r_b <= r_regs[w_rs2[RAW-1:0]];
`ifdef CORE_BRANCH_EN
          r_imm <= w_is_b ? w_imm_b : w_imm_i;
`else
          r_imm <= w_imm_i;
`endif
          r_state <= (w_legal && w_idx_ok) ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          r_result <= alu(w_f3, w_alt, r_a, w_opb);
`ifdef CORE_BRANCH_EN
          r_take   <= w_take;
          r_target <= w_target;
          r_state  <= (w_take && (w_target[1:0] != 2'b00)) ? S_HALT : S_WB;
`else
          r_state  <= S_WB;
`endif
        end
        S_WB: begin
          if ((w_is_r || w_is_i) && (w_rd != 5'd0)) r_regs[w_rd[RAW-1:0]] <= r_result;
          r_pc    <= w_next_pc;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign imem_req_o  = (r_state == S_FETCH) && !rst_i;
  assign imem_addr_o = r_pc;
  assign retire_o    = (r_state == S_WB) && !rst_i;
  assign retire_pc_o = retire_o ? r_pc : '0;
  assign halt_o      = (r_state == S_HALT) && !rst_i;

  always_comb begin
    dbg_rdata_o = '0;
    if ((dbg_raddr_i != 5'd0) && reg_ok(dbg_raddr_i)) dbg_rdata_o = r_regs[dbg_raddr_i[RAW-1:0]];
  end

endmodule

// File: tb/tb_multi_cycle_rv_core.sv
// Scoreboard bench for multi_cycle_rv_core: expected retire PCs queued by stimulus, checked by a monitor.
module tb_multi_cycle_rv_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req, ack, retire, halt;
  logic [31:0] addr, rdata, retire_pc, dbg_d;
  logic [4:0]  dbg_a = 5'd0;
  logic [31:0] mem [32];
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          wcnt = 0;

  assign ack   = (req && (wcnt >= ack_delay)) || force_ack;
  assign rdata = mem[addr[6:2]];
  always @(posedge clk) wcnt <= (req && !ack) ? wcnt + 1 : 0;

  multi_cycle_rv_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) u_dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .retire_o(retire), .retire_pc_o(retire_pc), .halt_o(halt),
    .dbg_raddr_i(dbg_a), .dbg_rdata_o(dbg_d));

  logic        rst16 = 1'b1;
  logic        req16, retire16, halt16;
  logic [31:0] addr16, retire_pc16, dbg_d16, w16;
  logic [4:0]  dbg_a16 = 5'd0;
  int          ret16 = 0;

  multi_cycle_rv_core #(.XLEN(32), .NREG(16), .RESET_PC(32'h40)) u_dut16 (
    .clk_i(clk), .rst_i(rst16), .imem_req_o(req16), .imem_addr_o(addr16), .imem_ack_i(req16),
    .imem_rdata_i(w16), .retire_o(retire16), .retire_pc_o(retire_pc16), .halt_o(halt16),
    .dbg_raddr_i(dbg_a16), .dbg_rdata_o(dbg_d16));

  always @(negedge clk) if (retire16) ret16++;

  typedef struct {
    logic [31:0] pc;
    int          gap;
  } exp_t;
  exp_t q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_ret = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL retire_unexpected: got retire at pc %h, required none", retire_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("retire_pc", retire_pc, e.pc);
        if (e.gap != 0) chk("retire_gap", cyc - last_ret, e.gap);
      end
      last_ret = cyc;
    end
    if (prev_wait && req) chk("addr_stable", addr, prev_addr);
    prev_wait = req && !ack;
    prev_addr = addr;
  end

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input int imm);
    logic [11:0] im;
    im = imm[11:0];
    return {im, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int imm);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("req_in_reset", {31'b0, req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("retire_after_reset", {31'b0, retire}, 32'd0);
    chk("retire_pc_after_reset", retire_pc, 32'd0);
    chk("halt_after_reset", {31'b0, halt}, 32'd0);
  endtask

  task automatic push_run(input int first, input int n, input int gap);
    for (int i = 0; i < n; i++) q.push_back('{pc: 32'(first + 4 * i), gap: (i == 0) ? 0 : gap});
  endtask

  task automatic wait_halt(input string name);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (halt) break;
    end
    chk(name, {31'b0, halt}, 32'd1);
    chk("req_when_halted", {31'b0, req}, 32'd0);
    chk("retire_queue_drained", q.size(), 32'd0);
  endtask

  task automatic chk_reg(input logic [4:0] idx, input logic [31:0] exp);
    @(negedge clk);
    dbg_a = idx;
    #1;
    chk($sformatf("x%0d", idx), dbg_d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    w16 = enc_r(7'h00, 3'b000, 5'd17, 5'd1, 5'd2);

    // Zero-wait fetch, then three wait states per fetch, same program.
    clear_mem();
    mem[0] = enc_i(3'b000, 5'd1, 5'd0, 5);
    mem[1] = enc_i(3'b000, 5'd2, 5'd1, -7);
    for (int pass = 0; pass < 2; pass++) begin
      ack_delay = (pass == 0) ? 0 : 3;
      do_reset();
      push_run(0, 2, (pass == 0) ? 4 : 7);
      wait_halt("halt_basic");
      chk_reg(5'd1, 32'h5);
      chk_reg(5'd2, 32'hFFFF_FFFE);
    end

    // ALU coverage.
    ack_delay = 0;
    clear_mem();
    mem[0]  = enc_i(3'b000, 5'd1, 5'd0, 1);
    mem[1]  = enc_i(3'b000, 5'd6, 5'd0, 31);
    mem[2]  = enc_r(7'h00, 3'b001, 5'd1, 5'd1, 5'd6);
    mem[3]  = enc_i(3'b000, 5'd4, 5'd0, 35);
    mem[4]  = enc_r(7'h20, 3'b101, 5'd3, 5'd1, 5'd4);
    mem[5]  = enc_r(7'h00, 3'b101, 5'd7, 5'd1, 5'd4);
    mem[6]  = enc_r(7'h00, 3'b011, 5'd5, 5'd0, 5'd1);
    mem[7]  = enc_r(7'h00, 3'b000, 5'd0, 5'd1, 5'd1);
    mem[8]  = enc_r(7'h00, 3'b010, 5'd8, 5'd1, 5'd0);
    mem[9]  = enc_r(7'h20, 3'b000, 5'd9, 5'd0, 5'd4);
    mem[10] = enc_i(3'b100, 5'd10, 5'd4, -1);
    mem[11] = enc_i(3'b010, 5'd11, 5'd4, -1);
    mem[12] = enc_i(3'b011, 5'd12, 5'd4, -1);
    mem[13] = enc_i(3'b101, 5'd13, 5'd1, 'h404);
    mem[14] = enc_r(7'h00, 3'b111, 5'd14, 5'd3, 5'd7);
    mem[15] = enc_i(3'b101, 5'd16, 5'd1, 31);
    mem[16] = enc_i(3'b001, 5'd17, 5'd4, 2);
    mem[17] = enc_i(3'b000, 5'd18, 5'd0, 'h400);
    do_reset();
    push_run(0, 18, 4);
    wait_halt("halt_alu");
    chk_reg(5'd1, 32'h8000_0000);
    chk_reg(5'd3, 32'hF000_0000);
    chk_reg(5'd7, 32'h1000_0000);
    chk_reg(5'd5, 32'h1);
    chk_reg(5'd0, 32'h0);
    chk_reg(5'd8, 32'h1);
    chk_reg(5'd9, 32'hFFFF_FFDD);
    chk_reg(5'd10, 32'hFFFF_FFDC);
    chk_reg(5'd11, 32'h0);
    chk_reg(5'd12, 32'h1);
    chk_reg(5'd13, 32'hF800_0000);
    chk_reg(5'd14, 32'h1000_0000);
    chk_reg(5'd16, 32'h1);
    chk_reg(5'd17, 32'h8C);
    chk_reg(5'd18, 32'h400);

    // Branch loop, then a taken branch to a misaligned target.
    clear_mem();
    mem[0] = enc_i(3'b000, 5'd1, 5'd0, 1);
    mem[1] = enc_i(3'b000, 5'd2, 5'd0, 3);
    mem[2] = enc_i(3'b000, 5'd1, 5'd1, 1);
    mem[3] = enc_i(3'b000, 5'd5, 5'd5, 1);
    mem[4] = enc_b(3'b001, 5'd1, 5'd2, -8);
    mem[5] = enc_b(3'b000, 5'd0, 5'd0, 2);
    do_reset();
`ifdef CORE_BRANCH_EN
    push_run(0, 5, 4);
    push_run(8, 3, 4);
    q[5].gap = 4;
    wait_halt("halt_branch");
    chk_reg(5'd1, 32'h3);
    chk_reg(5'd5, 32'h2);
`else
    push_run(0, 4, 4);
    wait_halt("halt_branch_disabled");
    chk_reg(5'd1, 32'h2);
    chk_reg(5'd5, 32'h1);
`endif

    // Reset while a fetch is pending and ack is high.
    clear_mem();
    mem[0] = enc_i(3'b000, 5'd1, 5'd0, 9);
    mem[1] = enc_i(3'b000, 5'd2, 5'd0, 1);
    ack_delay = 0;
    do_reset();
    push_run(0, 1, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (retire) break;
    end
    ack_delay = 1000;
    repeat (2) @(negedge clk);
    chk("stall_addr", addr, 32'h4);
    chk("stall_req", {31'b0, req}, 32'd1);
    rst = 1'b1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("req_in_reset_ack", {31'b0, req}, 32'd0);
    chk("retire_in_reset_ack", {31'b0, retire}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b0;
    #1;
    chk("addr_after_reset", addr, 32'h0);
    chk("req_after_reset", {31'b0, req}, 32'd1);
    chk_reg(5'd1, 32'h0);
    push_run(0, 2, 4);
    ack_delay = 0;
    wait_halt("halt_after_midfetch_reset");
    chk_reg(5'd1, 32'h9);
    chk_reg(5'd2, 32'h1);

    // NREG=16 instance: out-of-range rd halts; reset recovers at RESET_PC.
    @(negedge clk);
    rst16 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (halt16) break;
    end
    chk("nreg16_halt", {31'b0, halt16}, 32'd1);
    chk("nreg16_req", {31'b0, req16}, 32'd0);
    chk("nreg16_retires", ret16, 32'd0);
    w16 = enc_i(3'b000, 5'd3, 5'd0, 7);
    rst16 = 1'b1;
    @(posedge clk);
    #1;
    chk("nreg16_halt_in_reset", {31'b0, halt16}, 32'd0);
    @(negedge clk);
    rst16 = 1'b0;
    #1;
    chk("nreg16_req_resume", {31'b0, req16}, 32'd1);
    chk("nreg16_reset_pc", addr16, 32'h40);
    repeat (6) @(negedge clk);
    dbg_a16 = 5'd3;
    #1;
    chk("nreg16_x3", dbg_d16, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
